uart_piso_frame: RTL and testbench
==================================

UART_PISO_FRAME -- requirements
Module: uart_piso_frame

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter STOP_MAX, default 2, maximum supported stop bits; legal range 1..2.
REQ-003 baud_out  input  1  sole clock; one serial bit period per rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 send  input  1  request to transmit; accepted only in a cycle where ready=1.
REQ-006 data_in  input  DATA_W  payload; sampled on acceptance.
REQ-007 parity_type  input  2  00 none, 01 odd, 10 even, 11 none (reserved); sampled on acceptance.
REQ-008 stop_bits  input  1  0 = one stop bit, 1 = two stop bits (forced to one when STOP_MAX=1); sampled on acceptance.
REQ-009 ready  output  1  block can accept send this cycle.
REQ-010 data_out  output  1  serial line; idle high.
REQ-011 tx_active  output  1  frame in progress.
REQ-012 tx_done  output  1  one-cycle pulse after the final stop bit.
REQ-013 p_parity_out  output  1  parity bit of the current frame; 0 when parity is none.

Function
REQ-014 Frame order: start (0), data LSB first, optional parity, 1 or 2 stop bits (1).
REQ-015 FSM states are IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE->START on accepted send; START->DATA after 1 bit; DATA->PARITY or STOP after DATA_W bits; PARITY->STOP after 1 bit; STOP->IDLE after 1 or 2 bits.
REQ-017 data_out is registered and shows the bit of the current state from the edge after entry; the first bit (start 0) appears one baud_out edge after acceptance.
REQ-018 data_in, parity_type and stop_bits are latched on acceptance; changes mid-frame have no effect.
REQ-019 Parity is computed from the latched data: even = XOR of data bits; odd = its inverse.
REQ-020 The bit counter is sized $clog2(DATA_W+1) and resets to 0 on each state entry.
REQ-021 ready=1 in IDLE and during the last stop-bit cycle; ready=0 otherwise.
REQ-022 A send accepted in the last stop-bit cycle enters START directly: back-to-back frames with no idle bit, and tx_active stays 1.
REQ-023 tx_done pulses for one cycle at the end of every frame, including back-to-back frames.
REQ-024 tx_active=1 from the start bit through the last stop bit.
REQ-025 send while ready=0 is ignored and not queued.
REQ-026 p_parity_out holds the latched parity value from acceptance until the next acceptance.

Reset
REQ-027 When rst=0, all outputs and state clear immediately: data_out=1, tx_active=0, tx_done=0, p_parity_out=0, ready=1, FSM=IDLE, counter=0.
REQ-028 Reset mid-frame aborts the frame with no tx_done; the line returns high immediately.
REQ-029 Release of rst is synchronised in the design so that the first accepted send occurs at or after the second baud_out edge following deassertion.

Structure
REQ-030 A shared package uart_pkg holds the parity_type encoding constants, the FSM state typedef, and the DATA_W bounds.
REQ-031 One sub-module, uart_parity_gen (combinational, parametrised by DATA_W), computes the parity bit.
REQ-032 Shift register and counter live in uart_piso_frame; there are no other sub-modules.

Verification
REQ-033 8N1, send 0xA5 -> data_out 0,1,0,1,0,0,1,0,1,1 over 10 cycles; tx_done pulses on the following cycle.
REQ-034 8E1 with 0x03 -> parity bit 0; 8O1 with 0x03 -> parity bit 1; each frame is 11 bits.
REQ-035 DATA_W=5, two stop bits, 0x1F -> 0,1,1,1,1,1,1,1 (8 bits); ready is low until the final stop-bit cycle.
REQ-036 send held high continuously with 0x55 then 0xAA -> second start bit immediately follows the first stop bit; two tx_done pulses; tx_active never drops.
REQ-037 rst=0 asserted during data bit 3 -> data_out=1 and tx_active=0 the same cycle; no tx_done; next send transmits normally.
REQ-038 data_in changed mid-frame and send pulsed while busy -> transmitted frame unchanged and the second request dropped.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART PISO frame transmitter: parity encodings,
// FSM state type and the supported payload width range.
package uart_pkg;

    localparam int DATA_W_MIN = 5;
    localparam int DATA_W_MAX = 9;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;
    localparam logic [1:0] PAR_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    function automatic logic parity_enabled(input logic [1:0] parity_type);
        return (parity_type == PAR_ODD) || (parity_type == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity for one payload word. The reserved encoding behaves
// like "none": parity disabled and the bit forced to 0.
module uart_parity_gen
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        parity_type,
    output logic              parity_en,
    output logic              parity_bit
);

    always_comb begin
        parity_en  = parity_enabled(parity_type);
        parity_bit = 1'b0;
        if (parity_type == PAR_EVEN) begin
            parity_bit = ^data;
        end else if (parity_type == PAR_ODD) begin
            parity_bit = ~^data;
        end
    end

endmodule

// File: rtl/uart_piso_frame.sv
// Parallel-in serial-out UART frame transmitter clocked at the baud rate.
// state     | meaning
// ST_IDLE   | line high, waiting for send
// ST_START  | start bit (0) on the line
// ST_DATA   | payload bits, LSB first, one per cycle
// ST_PARITY | parity bit on the line
// ST_STOP   | one or two stop bits (1); last one may accept the next frame
module uart_piso_frame
    import uart_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int STOP_MAX = 2
) (
    input  logic              baud_out,
    input  logic              rst,
    input  logic              send,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        parity_type,
    input  logic              stop_bits,
    output logic              ready,
    output logic              data_out,
    output logic              tx_active,
    output logic              tx_done,
    output logic              p_parity_out
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
        $error("uart_piso_frame: DATA_W outside supported range");
    end
    if (STOP_MAX < 1 || STOP_MAX > 2) begin : g_bad_stop_max
        $error("uart_piso_frame: STOP_MAX outside supported range");
    end

    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              two_stop_q, two_stop_d;
    logic              par_en_q, par_en_d;
    logic              par_q, par_d;
    logic              line_q, line_d;
    logic              done_q, done_d;
    logic [1:0]        sync_q, sync_d;

    logic              gen_par_en;
    logic              gen_par_bit;
    logic [CNT_W-1:0]  stop_last;
    logic              last_stop;
    logic              accept;

    uart_parity_gen #(
        .DATA_W (DATA_W)
    ) u_parity_gen (
        .data        (data_in),
        .parity_type (parity_type),
        .parity_en   (gen_par_en),
        .parity_bit  (gen_par_bit)
    );

    // Acceptance is held off until reset release has passed through two flops.
    assign sync_d    = {sync_q[0], 1'b1};
    assign stop_last = two_stop_q ? CNT_W'(1) : '0;
    assign last_stop = (state_q == ST_STOP) && (cnt_q == stop_last);
    assign ready     = (state_q == ST_IDLE) || last_stop;
    assign accept    = send && ready && sync_q[1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        sh_d       = sh_q;
        two_stop_d = two_stop_q;
        par_en_d   = par_en_q;
        par_d      = par_q;
        line_d     = 1'b1;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
            end
            ST_START: begin
                state_d = ST_DATA;
                cnt_d   = '0;
                line_d  = sh_q[0];
                sh_d    = {1'b0, sh_q[DATA_W-1:1]};
            end
            ST_DATA: begin
                if (cnt_q == DATA_LAST) begin
                    cnt_d = '0;
                    if (par_en_q) begin
                        state_d = ST_PARITY;
                        line_d  = par_q;
                    end else begin
                        state_d = ST_STOP;
                    end
                end else begin
                    line_d = sh_q[0];
                    sh_d   = {1'b0, sh_q[DATA_W-1:1]};
                end
            end
            ST_PARITY: begin
                state_d = ST_STOP;
                cnt_d   = '0;
            end
            ST_STOP: begin
                if (last_stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A new request overrides the end-of-frame return to idle.
        if (accept) begin
            state_d    = ST_START;
            cnt_d      = '0;
            line_d     = 1'b0;
            sh_d       = data_in;
            two_stop_d = (STOP_MAX > 1) ? stop_bits : 1'b0;
            par_en_d   = gen_par_en;
            par_d      = gen_par_bit;
        end
    end

    always_ff @(posedge baud_out or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            two_stop_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            line_q     <= 1'b1;
            done_q     <= 1'b0;
            sync_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            two_stop_q <= two_stop_d;
            par_en_q   <= par_en_d;
            par_q      <= par_d;
            line_q     <= line_d;
            done_q     <= done_d;
            sync_q     <= sync_d;
        end
    end

    assign data_out     = line_q;
    assign tx_active    = (state_q != ST_IDLE);
    assign tx_done      = done_q;
    assign p_parity_out = par_q;

endmodule

// File: tb/tb_uart_piso_frame.sv
// Bench for uart_piso_frame: a frame-queue model checked every cycle on the
// 8-bit instance, plus literal frame expectations for both instances.
module tb_uart_piso_frame;

    logic       baud_out = 1'b0;
    logic       rst = 1'b0;
    logic       send = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [1:0] parity_type = 2'b00;
    logic       stop_bits = 1'b0;
    logic       ready, data_out, tx_active, tx_done, p_parity_out;

    logic       send5 = 1'b0;
    logic [4:0] d5 = 5'h00;
    logic       ready5, data_out5, tx_active5, tx_done5, p_parity_out5;

    always #5 baud_out = ~baud_out;

    uart_piso_frame #(.DATA_W(8), .STOP_MAX(2)) u8 (
        .baud_out(baud_out), .rst(rst), .send(send), .data_in(data_in),
        .parity_type(parity_type), .stop_bits(stop_bits), .ready(ready),
        .data_out(data_out), .tx_active(tx_active), .tx_done(tx_done),
        .p_parity_out(p_parity_out));

    uart_piso_frame #(.DATA_W(5), .STOP_MAX(2)) u5 (
        .baud_out(baud_out), .rst(rst), .send(send5), .data_in(d5),
        .parity_type(parity_type), .stop_bits(stop_bits), .ready(ready5),
        .data_out(data_out5), .tx_active(tx_active5), .tx_done(tx_done5),
        .p_parity_out(p_parity_out5));

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    bit   fr[$];
    logic m_done = 1'b0;
    logic m_par  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    // The whole line image of a frame, built from the framing rules.
    function automatic void load_frame(input logic [7:0] d, input logic [1:0] pt, input logic sb);
        int ones;
        ones = $countones(d);
        if (pt == 2'b10)      m_par = ((ones % 2) == 1);
        else if (pt == 2'b01) m_par = ((ones % 2) == 0);
        else                  m_par = 1'b0;
        fr.push_back(1'b0);
        for (int i = 0; i < 8; i++) fr.push_back(d[i]);
        if (pt == 2'b01 || pt == 2'b10) fr.push_back(m_par);
        fr.push_back(1'b1);
        if (sb) fr.push_back(1'b1);
    endfunction

    always @(negedge baud_out) begin : model_cmp
        int   sz;
        logic acc;
        if (!rst) begin
            chk1("rst_line", data_out, 1'b1);
            chk1("rst_active", tx_active, 1'b0);
            chk1("rst_ready", ready, 1'b1);
            chk1("rst_done", tx_done, 1'b0);
            chk1("rst_parity", p_parity_out, 1'b0);
            fr.delete();
            m_done = 1'b0;
            m_par  = 1'b0;
        end else begin
            sz = fr.size();
            chk1("line", data_out, (sz != 0) ? logic'(fr[0]) : 1'b1);
            chk1("active", tx_active, sz != 0);
            chk1("ready", ready, sz <= 1);
            chk1("done", tx_done, m_done);
            chk1("parity", p_parity_out, m_par);
            if (tx_done) done_cnt++;
            acc    = send && (sz <= 1);
            m_done = (sz == 1);
            if (sz != 0) void'(fr.pop_front());
            if (acc) load_frame(data_in, parity_type, stop_bits);
        end
    end

    task automatic step();
        @(posedge baud_out);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic sb);
        step();
        send = 1'b1;
        data_in = d;
        parity_type = pt;
        stop_bits = sb;
        step();
        send = 1'b0;
    endtask

    task automatic capture(input bit sel, input int n, output logic [31:0] ln,
                           output logic [31:0] ac, output logic [31:0] dn, output logic [31:0] rd);
        ln = '0; ac = '0; dn = '0; rd = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge baud_out);
            ln = {ln[30:0], sel ? data_out5  : data_out};
            ac = {ac[30:0], sel ? tx_active5 : tx_active};
            dn = {dn[30:0], sel ? tx_done5   : tx_done};
            rd = {rd[30:0], sel ? ready5     : ready};
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ln, ac, dn, rd;
        int d0;

        repeat (2) step();
        chk1("init_line", data_out, 1'b1);
        chk1("init_ready", ready, 1'b1);
        chk1("init_active", tx_active, 1'b0);
        chk1("init_done", tx_done, 1'b0);
        chk1("init_parity", p_parity_out, 1'b0);
        rst = 1'b1;
        repeat (4) step();

        // 8N1 0xA5
        send_frame(8'hA5, 2'b00, 1'b0);
        capture(1'b0, 11, ln, ac, dn, rd);
        chk("a5_line",   ln, {21'b0, 10'b0101001011, 1'b1});
        chk("a5_active", ac, {21'b0, 10'h3FF, 1'b0});
        chk("a5_done",   dn, {31'b0, 1'b1});
        chk("a5_ready",  rd, {21'b0, 10'b0000000001, 1'b1});

        // 8E1 and 8O1 with 0x03
        send_frame(8'h03, 2'b10, 1'b0);
        capture(1'b0, 12, ln, ac, dn, rd);
        chk("e1_line",   ln, {20'b0, 11'b01100000001, 1'b1});
        chk("e1_active", ac, {20'b0, 11'h7FF, 1'b0});
        chk1("e1_parity_out", p_parity_out, 1'b0);
        send_frame(8'h03, 2'b01, 1'b0);
        capture(1'b0, 12, ln, ac, dn, rd);
        chk("o1_line",   ln, {20'b0, 11'b01100000011, 1'b1});
        chk("o1_done",   dn, {31'b0, 1'b1});
        chk1("o1_parity_out", p_parity_out, 1'b1);

        // two stop bits and the reserved parity code, model-checked only
        send_frame(8'hC1, 2'b01, 1'b1);
        repeat (14) step();
        send_frame(8'h7E, 2'b11, 1'b1);
        repeat (13) step();

        // back-to-back with send held high
        step();
        fork
            begin
                send = 1'b1; data_in = 8'h55; parity_type = 2'b00; stop_bits = 1'b0;
                step();
                data_in = 8'hAA;
                repeat (10) @(posedge baud_out);
                #2 send = 1'b0;
            end
            begin
                @(negedge baud_out);
                capture(1'b0, 21, ln, ac, dn, rd);
            end
        join
        chk("b2b_line",   ln, {11'b0, 10'b0101010101, 10'b0010101011, 1'b1});
        chk("b2b_active", ac, {11'b0, 20'hFFFFF, 1'b0});
        chk("b2b_done",   dn, {11'b0, 10'b0, 10'b1000000000, 1'b1});
        chk("b2b_ready",  rd, {11'b0, 10'b0000000001, 10'b0000000001, 1'b1});

        // reset during data bit 3
        send_frame(8'h5A, 2'b00, 1'b0);
        repeat (4) step();
        chk1("pre_abort_active", tx_active, 1'b1);
        d0 = done_cnt;
        rst = 1'b0;
        #1;
        chk1("abort_line", data_out, 1'b1);
        chk1("abort_active", tx_active, 1'b0);
        repeat (2) step();
        rst = 1'b1;
        repeat (12) step();
        chk("abort_no_done", done_cnt - d0, 0);
        send_frame(8'h3C, 2'b00, 1'b0);
        capture(1'b0, 11, ln, ac, dn, rd);
        chk("retry_line", ln, {21'b0, 10'b0001111001, 1'b1});
        chk("retry_done", dn, {31'b0, 1'b1});

        // mid-frame input changes and a send while busy
        step();
        fork
            begin
                send = 1'b1; data_in = 8'h96; parity_type = 2'b00; stop_bits = 1'b0;
                step();
                send = 1'b0;
                repeat (3) step();
                data_in = 8'hFF; parity_type = 2'b01; stop_bits = 1'b1; send = 1'b1;
                step();
                send = 1'b0;
            end
            begin
                @(negedge baud_out);
                capture(1'b0, 14, ln, ac, dn, rd);
            end
        join
        chk("busy_line", ln, {18'b0, 10'b0011010011, 4'b1111});
        chk("busy_done", dn, {18'b0, 10'b0, 4'b1000});
        chk1("busy_parity_out", p_parity_out, 1'b0);

        // DATA_W=5 instance, two stop bits, 0x1F
        step();
        d5 = 5'h1F; parity_type = 2'b00; stop_bits = 1'b1; send5 = 1'b1;
        step();
        send5 = 1'b0;
        capture(1'b1, 9, ln, ac, dn, rd);
        chk("w5_line",   ln, {23'b0, 8'b01111111, 1'b1});
        chk("w5_ready",  rd, {23'b0, 8'b00000001, 1'b1});
        chk("w5_done",   dn, {31'b0, 1'b1});
        chk("w5_active", ac, {23'b0, 8'hFF, 1'b0});

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
